decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - ID stage: register file, operand bypass, load-use hazard, ID/EX register (optional DECODE_STALL_CNT_EN stall counter)
module decode_pipe #(
  parameter int DATA_W      = 32,
  parameter int CTL_W       = 13,
  parameter int MEMREAD_BIT = 5,
  parameter int ZERO_REG    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              in_valid,
  input  logic [CTL_W-1:0]  ctl_in,
  input  logic              imm_zext,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_out,
  output logic [4:0]        rs_out,
  output logic [4:0]        rt_out,
  output logic [4:0]        rd_out,
  output logic [31:0]       instr_out,
  output logic [CTL_W-1:0]  ctl_out,
  output logic              out_valid,
  output logic              hazard
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] rf_q [32];
  logic [DATA_W-1:0] rf_d [32];

  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_out_q, imm_out_d;
  logic [4:0]        rs_out_q, rs_out_d;
  logic [4:0]        rt_out_q, rt_out_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [31:0]       instr_out_q, instr_out_d;
  logic [CTL_W-1:0]  ctl_out_q, ctl_out_d;
  logic              out_valid_q, out_valid_d;

  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic              wr_ok;
  logic              hazard_w;
  logic [DATA_W-1:0] rs_rd, rt_rd, imm_ext;

  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign rd    = instruction[15:11];
  assign imm   = instruction[15:0];
  // a write to r0 is dropped when r0 is hardwired
  assign wr_ok = wr_en && !(ZR && (wr_addr == 5'd0));

  // write-first read: a same-cycle write to the source register wins over the array
  assign rs_rd   = (wr_ok && (wr_addr == rs)) ? wr_data : rf_q[rs];
  assign rt_rd   = (wr_ok && (wr_addr == rt)) ? wr_data : rf_q[rt];
  assign imm_ext = {{(DATA_W-16){imm[15] & ~imm_zext}}, imm};

  // load in EX whose destination is a source of the instruction in ID
  assign hazard_w = out_valid_q & ctl_out_q[MEMREAD_BIT] & in_valid & (rt_out_q != 5'd0) &
                    ((rt_out_q == rs) | (rt_out_q == rt));
  assign hazard   = hazard_w;

  // register file next state: single write port
  always_comb begin
    rf_d = rf_q;
    if (wr_ok) rf_d[wr_addr] = wr_data;
  end

  // register file storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // ID/EX register next state: flush > stall > hazard bubble > normal load
  always_comb begin
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_out_d   = imm_out_q;
    rs_out_d    = rs_out_q;
    rt_out_d    = rt_out_q;
    rd_out_d    = rd_out_q;
    instr_out_d = instr_out_q;
    ctl_out_d   = ctl_out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
      ctl_out_d   = '0;
    end else if (stall_in) begin
      out_valid_d = out_valid_q;
    end else if (hazard_w) begin
      out_valid_d = 1'b0;
      ctl_out_d   = '0;
    end else begin
      rs_data_d   = rs_rd;
      rt_data_d   = rt_rd;
      imm_out_d   = imm_ext;
      rs_out_d    = rs;
      rt_out_d    = rt;
      rd_out_d    = rd;
      instr_out_d = instruction;
      out_valid_d = in_valid;
      ctl_out_d   = in_valid ? ctl_in : '0;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_out_q   <= '0;
      rs_out_q    <= '0;
      rt_out_q    <= '0;
      rd_out_q    <= '0;
      instr_out_q <= '0;
      ctl_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_out_q   <= imm_out_d;
      rs_out_q    <= rs_out_d;
      rt_out_q    <= rt_out_d;
      rd_out_q    <= rd_out_d;
      instr_out_q <= instr_out_d;
      ctl_out_q   <= ctl_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rs_data   = rs_data_q;
  assign rt_data   = rt_data_q;
  assign imm_out   = imm_out_q;
  assign rs_out    = rs_out_q;
  assign rt_out    = rt_out_q;
  assign rd_out    = rd_out_q;
  assign instr_out = instr_out_q;
  assign ctl_out   = ctl_out_q;
  assign out_valid = out_valid_q;

`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // count load-use bubbles actually inserted, saturating
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_w && !stall_in && !flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
